// File: rtl/gpio_frame_reader_pkg.sv
// Shared widths and pixel packing for the GPIO frame reader.
// These constants mirror the solver's host-port layout.
package gpio_frame_reader_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int HOST_TX_BIT   = 15;
  localparam int PIX_IDX_WIDTH = 15;

  // Stream word order is {ux, uy, rho, u2}, with ux in the top 16 bits.
  function automatic logic [4*DATA_WIDTH-1:0] pack_pixel(
    input logic [DATA_WIDTH-1:0] ux,
    input logic [DATA_WIDTH-1:0] uy,
    input logic [DATA_WIDTH-1:0] rho,
    input logic [DATA_WIDTH-1:0] u2
  );
    return {ux, uy, rho, u2};
  endfunction

endpackage

// File: rtl/gpio_frame_reader.sv
// Host-side initiator that sweeps the solver's GPIO pixel port and streams
// each settled pixel sample out as one 64-bit valid/ready word.
module gpio_frame_reader
  import gpio_frame_reader_pkg::*;
#(
  parameter int N_PIXELS      = 2500,
  parameter int IDX_WIDTH     = PIX_IDX_WIDTH,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         frame_ready,
  output logic [DATA_WIDTH-1:0]        GPIOi,
  input  logic signed [DATA_WIDTH-1:0] GPIOux,
  input  logic signed [DATA_WIDTH-1:0] GPIOuy,
  input  logic signed [DATA_WIDTH-1:0] GPIOrho,
  input  logic signed [DATA_WIDTH-1:0] GPIOu2,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [4*DATA_WIDTH-1:0]      m_data,
  output logic [IDX_WIDTH-1:0]         m_index,
  output logic                         m_last,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RDY,
    SETTLE,
    EMIT
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX    = IDX_WIDTH'(N_PIXELS - 1);
  localparam logic [3:0]           SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t               state;
  logic [IDX_WIDTH-1:0] idx;
  logic [IDX_WIDTH-1:0] next_idx;
  logic [3:0]           cnt;

  assign next_idx = idx + IDX_WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      GPIOi   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_index <= '0;
      m_last  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // A start landing on the done cycle belongs to the finished frame.
        IDLE: begin
          if (start && !done) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (frame_ready) begin
            GPIOi <= {1'b1, idx};
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt + 4'd1;
          if (cnt == SETTLE_LAST) begin
            m_data  <= pack_pixel(GPIOux, GPIOuy, GPIOrho, GPIOu2);
            m_index <= idx;
            m_last  <= (idx == LAST_IDX);
            m_valid <= 1'b1;
            state   <= EMIT;
          end
        end
        // GPIOi holds the current index for as long as the host stalls.
        EMIT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (m_last) begin
              GPIOi <= '0;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              idx   <= next_idx;
              GPIOi <= {1'b1, next_idx};
              cnt   <= '0;
              state <= SETTLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_frame_reader.sv
// Scoreboard bench for gpio_frame_reader with a 4-pixel frame and a
// settle-aware solver model that drives 0xDEAD until data is stable.
`timescale 1ns/1ps
module tb_gpio_frame_reader;

  localparam int N_PIX  = 4;
  localparam int SETTLE = 2;

  typedef struct {
    logic [14:0] idx;
    logic [63:0] data;
    logic        last;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        frame_ready = 1'b0;
  logic        m_ready = 1'b1;
  logic [15:0] GPIOi;
  logic signed [15:0] GPIOux, GPIOuy, GPIOrho, GPIOu2;
  logic        m_valid;
  logic [63:0] m_data;
  logic [14:0] m_index;
  logic        m_last;
  logic        busy;
  logic        done;

  vec_t vecs[N_PIX];
  vec_t sb[$];
  int   hs_cyc[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   done_count = 0;
  int   last_done_cyc = 0;
  int   start_cyc = 0;

  logic [15:0] gpio_q = 16'h0000;
  logic [15:0] pv;
  logic        settled;

  gpio_frame_reader #(
    .N_PIXELS(N_PIX),
    .IDX_WIDTH(15),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .frame_ready(frame_ready),
    .GPIOi(GPIOi),
    .GPIOux(GPIOux),
    .GPIOuy(GPIOuy),
    .GPIOrho(GPIOrho),
    .GPIOu2(GPIOu2),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_index(m_index),
    .m_last(m_last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Solver model: data is valid only once GPIOi has been stable for a full cycle.
  always @(posedge clk) gpio_q <= GPIOi;
  assign pv      = {1'b0, GPIOi[14:0]};
  assign settled = GPIOi[15] && (GPIOi == gpio_q);
  assign GPIOux  = settled ? pv : 16'hDEAD;
  assign GPIOuy  = settled ? 16'h0000 - pv : 16'hDEAD;
  assign GPIOrho = settled ? 16'h1000 + pv : 16'hDEAD;
  assign GPIOu2  = settled ? pv * pv : 16'hDEAD;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pushFrame();
    foreach (vecs[i]) sb.push_back(vecs[i]);
  endtask

  task automatic waitDone(input string name, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("[TB] FAIL %s: got no done within %0d cycles, expected done", name, bound);
    end
  endtask

  task automatic waitGpio(input string name, input logic [15:0] value, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (GPIOi == value) begin
        seen = 1'b1;
        break;
      end
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("[TB] FAIL %s: got GPIOi 0x%0h, expected 0x%0h within %0d cycles", name, GPIOi, value, bound);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, just after the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (rst && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_word: got index %0d, expected no word", m_index);
      end else begin
        vec_t exp_word;
        exp_word = sb.pop_front();
        checkOutput("word_data", m_data, exp_word.data);
        checkOutput("word_index", 64'(m_index), 64'(exp_word.idx));
        checkOutput("word_last", 64'(m_last), 64'(exp_word.last));
        checkOutput("word_gpio", 64'(GPIOi), 64'({1'b1, exp_word.idx}));
      end
      hs_cyc.push_back(cyc);
    end
    if (rst && done) begin
      done_count++;
      last_done_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] held_data;
    int          dc;
    bit          seen;

    for (int i = 0; i < N_PIX; i++) begin
      vecs[i].idx  = 15'(i);
      vecs[i].data = {16'(i), 16'(-i), 16'(32'h1000 + i), 16'(i * i)};
      vecs[i].last = (i == N_PIX - 1);
    end

    // Reset state
    #12;
    checkOutput("rst_gpio", 64'(GPIOi), 64'h0);
    checkOutput("rst_valid", 64'(m_valid), 64'h0);
    checkOutput("rst_data", m_data, 64'h0);
    checkOutput("rst_index", 64'(m_index), 64'h0);
    checkOutput("rst_last", 64'(m_last), 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_done", 64'(done), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    frame_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Basic sweep with timing
    $display("[TB] basic sweep");
    hs_cyc.delete();
    pushFrame();
    applyStimulus();
    checkOutput("basic_busy_wait", 64'(busy), 64'h1);
    checkOutput("basic_gpio_wait", 64'(GPIOi), 64'h0);
    @(negedge clk);
    checkOutput("basic_gpio_first", 64'(GPIOi), 64'h8000);
    checkOutput("basic_valid_early", 64'(m_valid), 64'h0);
    waitDone("basic_done", 60);
    checkOutput("basic_done_gpio", 64'(GPIOi), 64'h0);
    checkOutput("basic_done_busy", 64'(busy), 64'h0);
    @(negedge clk);
    checkOutput("basic_done_pulse", 64'(done), 64'h0);
    checkOutput("basic_sb_empty", 64'(sb.size()), 64'h0);
    checkOutput("basic_hs_count", 64'(hs_cyc.size()), 64'(N_PIX));
    checkOutput("basic_done_cycle", 64'(last_done_cyc), 64'(start_cyc + 2 + N_PIX * (SETTLE + 1)));
    if (hs_cyc.size() == N_PIX) begin
      checkOutput("basic_first_valid", 64'(hs_cyc[0]), 64'(start_cyc + 2 + SETTLE));
      for (int i = 1; i < N_PIX; i++)
        checkOutput("basic_spacing", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'(SETTLE + 1));
    end

    // Ready gating, then a mid-sweep frame_ready drop that must be ignored
    $display("[TB] ready gating");
    frame_ready = 1'b0;
    pushFrame();
    applyStimulus();
    for (int i = 0; i < 10; i++) begin
      checkOutput("gate_busy", 64'(busy), 64'h1);
      checkOutput("gate_gpio", 64'(GPIOi), 64'h0);
      if (i < 9) @(negedge clk);
    end
    frame_ready = 1'b1;
    @(negedge clk);
    checkOutput("gate_gpio_start", 64'(GPIOi), 64'h8000);
    frame_ready = 1'b0;
    waitDone("gate_done", 60);
    frame_ready = 1'b1;
    @(negedge clk);
    checkOutput("gate_sb_empty", 64'(sb.size()), 64'h0);

    // Backpressure on index 1
    $display("[TB] backpressure");
    pushFrame();
    applyStimulus();
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_valid && m_index == 15'd1) begin
        seen = 1'b1;
        break;
      end
    end
    m_ready = 1'b0;
    checkOutput("bp_reached_idx1", 64'(seen), 64'h1);
    held_data = m_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid_held", 64'(m_valid), 64'h1);
      checkOutput("bp_data_held", m_data, held_data);
      checkOutput("bp_index_held", 64'(m_index), 64'h1);
      checkOutput("bp_gpio_held", 64'(GPIOi), 64'h8001);
    end
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_valid_drop", 64'(m_valid), 64'h0);
    checkOutput("bp_gpio_next", 64'(GPIOi), 64'h8002);
    waitDone("bp_done", 60);
    @(negedge clk);
    checkOutput("bp_sb_empty", 64'(sb.size()), 64'h0);

    // Start ignored mid-sweep and on the done cycle
    $display("[TB] start ignored");
    dc = done_count;
    pushFrame();
    applyStimulus();
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("ign_done", 60);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("ign_busy", 64'(busy), 64'h0);
    checkOutput("ign_gpio", 64'(GPIOi), 64'h0);
    checkOutput("ign_done_count", 64'(done_count - dc), 64'h1);
    checkOutput("ign_sb_empty", 64'(sb.size()), 64'h0);

    // Asynchronous reset at index 2, then a clean frame
    $display("[TB] async reset");
    pushFrame();
    applyStimulus();
    waitGpio("ar_reach_idx2", 16'h8002, 40);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("ar_gpio", 64'(GPIOi), 64'h0);
    checkOutput("ar_valid", 64'(m_valid), 64'h0);
    checkOutput("ar_busy", 64'(busy), 64'h0);
    checkOutput("ar_data", m_data, 64'h0);
    sb.delete();
    dc = done_count;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("ar_no_done", 64'(done_count - dc), 64'h0);
    pushFrame();
    applyStimulus();
    waitDone("ar_clean_done", 60);
    @(negedge clk);
    checkOutput("ar_clean_sb_empty", 64'(sb.size()), 64'h0);
    checkOutput("ar_clean_done_count", 64'(done_count - dc), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
